// File: rtl/best_d_seq_if.sv
// ---------------------------------------------------------------------------
// best_d_seq_if
//   Request/response bundle for the best_d_seq parameter unit.
//   The master (encoder control FSM) drives start/n/t; the slave (best_d_seq)
//   returns ready/valid plus the d/u/err result.
//   Signals:
//     start  master->slave  request, sampled while ready=1
//     n      master->slave  block length (N_W bits)
//     t      master->slave  weight (T_W bits)
//     ready  slave->master  idle, a start will be accepted
//     valid  slave->master  one-cycle pulse: d/u/err updated
//     d      slave->master  result d (N_W bits)
//     u      slave->master  result u = ceil(log2 d) (U_W bits)
//     err    slave->master  last request had t==0
// ---------------------------------------------------------------------------
interface best_d_seq_if #(
   parameter int unsigned N_W = 21,
   parameter int unsigned T_W = 4,
   parameter int unsigned U_W = 5
);
   logic           start;
   logic [N_W-1:0] n;
   logic [T_W-1:0] t;
   logic           ready;
   logic           valid;
   logic [N_W-1:0] d;
   logic [U_W-1:0] u;
   logic           err;

   modport master (output start, n, t, input ready, valid, d, u, err);
   modport slave  (input start, n, t, output ready, valid, d, u, err);
endinterface

// File: rtl/best_d_seq.sv
// ---------------------------------------------------------------------------
// best_d_seq
//   Multi-cycle best_d parameter unit for the constant-weight encoder.
//   Computes d = floor(ln2*(n-(t-1)/2)/t) and u = ceil(log2 d) using a
//   fixed-point ln2 constant and a bit-serial restoring divider.
//   Evaluated as floor((2n-t+1)*LN2_Q / (2t) / 2^FRAC).
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  best_d_seq_if.slave: start/n/t in, ready/valid/d/u/err out
//
//   Sequence: IDLE -accept-> LOAD -> DIV (NUM_W cycles) -> NORM -> IDLE.
//   valid rises NUM_W+2 edges after the accept edge (40 at defaults).
//   t==0 bypasses DIV and reports err=1, d=0, u=0 two edges after accept.
//
//   Configuration macro:
//     BEST_D_POW2_EN  defined: d = 1<<u (all ones when u reaches N_W)
//                     undefined: d = exact floor quotient
// ---------------------------------------------------------------------------
module best_d_seq #(
   parameter int unsigned N_W   = 21,
   parameter int unsigned T_W   = 4,
   parameter int unsigned FRAC  = 16,
   parameter int unsigned LN2_Q = 45426,
   parameter int unsigned U_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   best_d_seq_if.slave bus
);

   localparam int unsigned A_W   = N_W + 2;            // signed 2n-t+1
   localparam int unsigned NUM_W = N_W + 1 + FRAC;     // dividend / quotient
   localparam int unsigned DEN_W = T_W + 1;            // 2t
   localparam int unsigned REM_W = T_W + 2;            // remainder
   localparam int unsigned CNT_W = $clog2(NUM_W + 1);
   localparam int unsigned DQ_W  = NUM_W - FRAC;       // integer part of q

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_NORM = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [N_W-1:0]   n_q, n_d;
   logic [T_W-1:0]   t_q, t_d;
   logic [NUM_W-1:0] num_q, num_d;
   logic [DEN_W-1:0] den_q, den_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic [NUM_W-1:0] quot_q, quot_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_W-1:0]   res_d_q, res_d_d;
   logic [U_W-1:0]   res_u_q, res_u_d;
   logic             err_q, err_d;
   logic             valid_q, valid_d;

   // ---------------- LOAD operands ----------------
   // a is formed in A_W bits; a set MSB means 2n+1 < t and a clamps to 0.
   logic [A_W-1:0]   a_raw;
   logic [N_W:0]     a_clamp;
   logic [NUM_W-1:0] num_load;
   logic [DEN_W-1:0] den_load;

   always_comb begin
      a_raw    = {1'b0, n_q, 1'b0} - {{(A_W-T_W){1'b0}}, t_q} + A_W'(1);
      a_clamp  = a_raw[A_W-1] ? '0 : a_raw[N_W:0];
      num_load = NUM_W'(a_clamp) * NUM_W'(LN2_Q);
      den_load = {t_q, 1'b0};
   end

   // ---------------- restoring divider step ----------------
   // rem < den always holds, so the shifted remainder fits REM_W+1 bits and
   // the post-subtract remainder fits REM_W bits.
   logic [REM_W:0]   rem_sh;
   logic             q_bit;
   logic [REM_W-1:0] rem_sub;

   always_comb begin
      rem_sh  = {rem_q, num_q[NUM_W-1]};
      q_bit   = (rem_sh >= {{(REM_W+1-DEN_W){1'b0}}, den_q});
      rem_sub = rem_sh[REM_W-1:0] - {1'b0, den_q};
   end

   // ---------------- NORM: integer quotient, u, final d ----------------
   logic [DQ_W-1:0] dq;
   logic [DQ_W-1:0] dq_m1;
   logic [U_W-1:0]  u_enc;
   logic            unused_frac;
   logic [N_W-1:0]  norm_d;
   logic [U_W-1:0]  norm_u;
   logic            norm_err;

   assign dq          = quot_q[NUM_W-1:FRAC];
   assign unused_frac = ^quot_q[FRAC-1:0];   // fraction bits are floored away

   // ceil(log2 x) for x>=1 equals the bit length of x-1 (0 for x==1).
   always_comb begin
      dq_m1 = dq - DQ_W'(1);
      u_enc = '0;
      for (int i = 0; i < int'(DQ_W); i++) begin
         if (dq_m1[i]) u_enc = U_W'(i + 1);
      end
   end

   always_comb begin
      norm_d   = '0;
      norm_u   = '0;
      norm_err = 1'b0;
      if (t_q == '0) begin
         norm_err = 1'b1;
      end else if (dq == '0) begin
         norm_d = N_W'(1);
      end else if (dq[N_W]) begin
         // dq >= 2^N_W cannot be represented: saturate
         norm_d = '1;
         norm_u = U_W'(N_W);
      end else begin
         norm_u = u_enc;
`ifdef BEST_D_POW2_EN
         // 1<<N_W does not fit in N_W bits; report all ones instead
         if (u_enc >= U_W'(N_W)) norm_d = '1;
         else                    norm_d = N_W'(1) << u_enc;
`else
         norm_d = dq[N_W-1:0];
`endif
      end
   end

   // ---------------- FSM / datapath next state ----------------
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      t_d     = t_q;
      num_d   = num_q;
      den_d   = den_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      cnt_d   = cnt_q;
      res_d_d = res_d_q;
      res_u_d = res_u_q;
      err_d   = err_q;
      valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               n_d     = bus.n;
               t_d     = bus.t;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            num_d   = num_load;
            den_d   = den_load;
            rem_d   = '0;
            quot_d  = '0;
            cnt_d   = CNT_W'(NUM_W - 1);
            state_d = (t_q == '0) ? S_NORM : S_DIV;
         end
         S_DIV: begin
            num_d  = {num_q[NUM_W-2:0], 1'b0};
            quot_d = {quot_q[NUM_W-2:0], q_bit};
            rem_d  = q_bit ? rem_sub : rem_sh[REM_W-1:0];
            if (cnt_q == '0) state_d = S_NORM;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_NORM: begin
            res_d_d = norm_d;
            res_u_d = norm_u;
            err_d   = norm_err;
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         t_q     <= '0;
         num_q   <= '0;
         den_q   <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         cnt_q   <= '0;
         res_d_q <= '0;
         res_u_q <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         t_q     <= t_d;
         num_q   <= num_d;
         den_q   <= den_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         cnt_q   <= cnt_d;
         res_d_q <= res_d_d;
         res_u_q <= res_u_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end

   assign bus.ready = (state_q == S_IDLE);
   assign bus.valid = valid_q;
   assign bus.d     = res_d_q;
   assign bus.u     = res_u_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_best_d_seq.sv
// ---------------------------------------------------------------------------
// tb_best_d_seq
//   Directed bench for best_d_seq. Expected d/u values are hand-computed from
//   floor((2n-t+1)*45426 / (2t*65536)); under BEST_D_POW2_EN d becomes 1<<u.
// ---------------------------------------------------------------------------
module tb_best_d_seq;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   fails  = 0;
   int   vcount = 0;

   best_d_seq_if bus ();

   best_d_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // counts valid cycles as seen by the rising edge
   always @(posedge clk) if (bus.valid === 1'b1) vcount++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // expected d from the raw integer quotient dq and u
   function automatic int exp_dv(input int dq, input int u);
`ifdef BEST_D_POW2_EN
      if (dq == 0)      return 1;
      else if (u >= 21) return 2097151;
      else              return 1 << u;
`else
      if (dq == 0) return 1;
      else         return dq;
`endif
   endfunction

   // one request from idle; checks latency, result and single-cycle valid
   task automatic do_req(input logic [20:0] nn, input logic [3:0] tt, input int e_d,
                         input int e_u, input logic e_err, input int e_lat, input string tag);
      int cyc;
      @(negedge clk);
      chk({tag, "_ready"}, 32'(bus.ready), 1);
      bus.start = 1'b1;
      bus.n     = nn;
      bus.t     = tt;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         bus.start = 1'b0;
         bus.n     = ~nn;   // changes after accept must not matter
         bus.t     = ~tt;
      end while (bus.valid !== 1'b1 && cyc < 200);
      chk({tag, "_lat"}, 32'(cyc - 1), 32'(e_lat));
      chk({tag, "_d"},   32'(bus.d),   32'(e_d));
      chk({tag, "_u"},   32'(bus.u),   32'(e_u));
      chk({tag, "_err"}, 32'(bus.err), 32'(e_err));
      @(negedge clk);
      chk({tag, "_vpulse"}, 32'(bus.valid), 0);
      chk({tag, "_dhold"},  32'(bus.d),     32'(e_d));
   endtask

   int sw_dq [8] = '{726816, 363407, 242271, 181703, 145362, 121135, 103830, 90851};
   int sw_u  [8] = '{20, 19, 18, 18, 18, 17, 17, 17};

   initial begin
      int v0;
      int cyc;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.n     = '0;
      bus.t     = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(bus.ready), 1);
      chk("rst_valid", 32'(bus.valid), 0);
      chk("rst_d",     32'(bus.d),     0);
      chk("rst_u",     32'(bus.u),     0);
      chk("rst_err",   32'(bus.err),   0);
      rst = 1'b0;

      do_req(21'd1048576, 4'd1, exp_dv(726816, 20), 20, 1'b0, 40, "T2");
      do_req(21'd1048576, 4'd8, exp_dv(90851, 17),  17, 1'b0, 40, "T3");
      do_req(21'd123,     4'd0, 0,                  0,  1'b1, 2,  "T5_t0");
      do_req(21'd1048576, 4'd1, exp_dv(726816, 20), 20, 1'b0, 40, "T5_clr");
      do_req(21'd0,       4'd8, exp_dv(0, 0),       0,  1'b0, 40, "T6");
      do_req(21'd2,       4'd1, exp_dv(1, 0),       0,  1'b0, 40, "dq1");
      do_req(21'd3,       4'd1, exp_dv(2, 1),       1,  1'b0, 40, "dq2");
      do_req(21'd2097151, 4'd1, exp_dv(1453631, 21), 21, 1'b0, 40, "nmax");

      // T4: back-to-back sweep t=1..8, restarting in each valid cycle,
      // with stray start pulses while busy
      v0 = vcount;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("T4_t%0d_ready", i + 1), 32'(bus.ready), 1);
         bus.start = 1'b1;
         bus.n     = 21'd1048576;
         bus.t     = 4'(i + 1);
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
            bus.start = (cyc == 10 || cyc == 25);
            bus.n     = bus.start ? 21'd7 : 21'd1048576;
            bus.t     = bus.start ? 4'd0  : 4'(i + 1);
         end while (bus.valid !== 1'b1 && cyc < 200);
         chk($sformatf("T4_t%0d_lat", i + 1), 32'(cyc - 1), 40);
         chk($sformatf("T4_t%0d_d",   i + 1), 32'(bus.d),   32'(exp_dv(sw_dq[i], sw_u[i])));
         chk($sformatf("T4_t%0d_u",   i + 1), 32'(bus.u),   32'(sw_u[i]));
         chk($sformatf("T4_t%0d_err", i + 1), 32'(bus.err), 0);
      end
      bus.start = 1'b0;
      @(negedge clk);
      chk("T4_vpulse", 32'(bus.valid), 0);
      @(negedge clk);
      chk("T4_count", 32'(vcount - v0), 8);

      // T1: reset in the middle of a division
      v0 = vcount;
      @(negedge clk);
      bus.start = 1'b1;
      bus.n     = 21'd1048576;
      bus.t     = 4'd1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (14) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("T1_ready", 32'(bus.ready), 1);
      chk("T1_valid", 32'(bus.valid), 0);
      chk("T1_d",     32'(bus.d),     0);
      chk("T1_u",     32'(bus.u),     0);
      chk("T1_err",   32'(bus.err),   0);
      @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      chk("T1_novalid", 32'(vcount - v0), 0);
      chk("T1_idle_d",  32'(bus.d),       0);
      do_req(21'd1048576, 4'd3, exp_dv(242271, 18), 18, 1'b0, 40, "T1_post");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
